// File: rtl/disp_mux_pkg.sv
// Shared types and constants for the multiplexed 4-digit seven-segment display scheduler.
package disp_mux_pkg;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_ON    = 1'b1
  } state_t;

  localparam int NUM_DIGITS = 4;
  localparam int DIG_W      = $clog2(NUM_DIGITS);

  localparam logic [NUM_DIGITS-1:0] AN_OFF     = 4'hF;
  localparam logic [7:0]            SSEG_BLANK = 8'hFF;

endpackage

// File: rtl/hex_to_sseg.sv
// Combinational hex nibble to active-low gfedcba segment decoder.
module hex_to_sseg (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    case (nibble)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
  end

endmodule

// File: rtl/disp_mux_scheduler.sv
// Time-multiplexed 4-digit display scheduler with frame-aligned data commit.
// Optional build macro LEADING_ZERO_BLANK_EN darkens leading zero digits (digit0 always shown).
module disp_mux_scheduler
  import disp_mux_pkg::*;
#(
  parameter int SLOT_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                  clk_amisha,
  input  logic                  reset_n_amisha,
  input  logic                  load_amisha,
  input  logic [15:0]           din_amisha,
  input  logic [NUM_DIGITS-1:0] dp_amisha,
  input  logic [NUM_DIGITS-1:0] mask_amisha,
  output logic                  load_ack_amisha,
  output logic                  frame_tick_amisha,
  output logic [NUM_DIGITS-1:0] an_amisha,
  output logic [7:0]            sseg_amisha
);

  localparam int CNT_W = $clog2(SLOT_CYCLES);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(SLOT_CYCLES - BLANK_CYCLES - 1);
  localparam logic [DIG_W-1:0] DIG_LAST   = DIG_W'(NUM_DIGITS - 1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DIG_W-1:0]        digit_q, digit_d;
  logic                    commit;

  logic                    pending_q;
  logic [15:0]             pend_din_q, shd_din_q;
  logic [NUM_DIGITS-1:0]   pend_dp_q, shd_dp_q;
  logic [NUM_DIGITS-1:0]   pend_mask_q, shd_mask_q;

  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [7:0]              sseg_q, sseg_d;
  logic                    load_ack_q, frame_tick_q;

  logic [3:0]              cur_nib;
  logic [6:0]              cur_seg;
  logic                    lz_dark;

  assign cur_nib = shd_din_q[{digit_q, 2'b00} +: 4];

  hex_to_sseg u_dec (
    .nibble (cur_nib),
    .seg    (cur_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // Dark when this digit and every higher digit carry a zero nibble and no decimal point.
  always_comb begin
    lz_dark = (digit_q != '0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i >= int'(digit_q) && (shd_din_q[4*i +: 4] != 4'h0 || shd_dp_q[i])) lz_dark = 1'b0;
    end
  end
`else
  assign lz_dark = 1'b0;
`endif

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    digit_d = digit_q;
    commit  = 1'b0;
    an_d    = AN_OFF;
    sseg_d  = SSEG_BLANK;

    unique case (state_q)
      S_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = S_ON;
          cnt_d   = '0;
        end
      end
      S_ON: begin
        if (cnt_q == ON_LAST) begin
          state_d = S_BLANK;
          cnt_d   = '0;
          digit_d = digit_q + 1'b1;
          commit  = (digit_q == DIG_LAST);
        end
      end
    endcase

    // Digit index and shadow only change on ON->BLANK edges, so current values are valid here.
    if (state_d == S_ON && !lz_dark) begin
      sseg_d = {~shd_dp_q[digit_q], cur_seg};
      if (shd_mask_q[digit_q]) an_d[digit_q] = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_amisha or negedge reset_n_amisha) begin
    if (!reset_n_amisha) begin
      state_q      <= S_BLANK;
      cnt_q        <= '0;
      digit_q      <= '0;
      pending_q    <= 1'b0;
      pend_din_q   <= '0;
      pend_dp_q    <= '0;
      pend_mask_q  <= '0;
      shd_din_q    <= '0;
      shd_dp_q     <= '0;
      shd_mask_q   <= AN_OFF;
      an_q         <= AN_OFF;
      sseg_q       <= SSEG_BLANK;
      load_ack_q   <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      digit_q      <= digit_d;
      an_q         <= an_d;
      sseg_q       <= sseg_d;
      frame_tick_q <= commit;
      load_ack_q   <= commit && pending_q;

      // The old buffer commits even if a new load lands on the same edge.
      if (commit && pending_q) begin
        shd_din_q  <= pend_din_q;
        shd_dp_q   <= pend_dp_q;
        shd_mask_q <= pend_mask_q;
      end

      if (load_amisha) begin
        pend_din_q  <= din_amisha;
        pend_dp_q   <= dp_amisha;
        pend_mask_q <= mask_amisha;
        pending_q   <= 1'b1;
      end else if (commit) begin
        pending_q   <= 1'b0;
      end
    end
  end

  assign an_amisha         = an_q;
  assign sseg_amisha       = sseg_q;
  assign load_ack_amisha   = load_ack_q;
  assign frame_tick_amisha = frame_tick_q;

endmodule

// File: tb/tb_disp_mux_scheduler.sv
// Directed bench for disp_mux_scheduler with SLOT_CYCLES=8, BLANK_CYCLES=2.
module tb_disp_mux_scheduler;

  localparam int SLOT  = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * SLOT;

  typedef struct {
    logic [15:0]      din;
    logic [3:0]       dp;
    logic [3:0]       mask;
    logic             pre;
    logic [15:0]      pre_din;
    logic [3:0][3:0]  an;
    logic [3:0][7:0]  sseg;
    logic [3:0]       care;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] din = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  mask = '0;
  logic        load_ack, frame_tick;
  logic [3:0]  an;
  logic [7:0]  sseg;

  int total = 0;
  int bad   = 0;

  disp_mux_scheduler #(.SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK)) dut (
    .clk_amisha        (clk),
    .reset_n_amisha    (reset_n),
    .load_amisha       (load),
    .din_amisha        (din),
    .dp_amisha         (dp),
    .mask_amisha       (mask),
    .load_ack_amisha   (load_ack),
    .frame_tick_amisha (frame_tick),
    .an_amisha         (an),
    .sseg_amisha       (sseg)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] d, input logic [3:0] p, input logic [3:0] m,
                              input logic [3:0][3:0] a, input logic [3:0][7:0] s,
                              input logic [3:0] c);
    vec_t v;
    v.din = d; v.dp = p; v.mask = m; v.pre = 1'b0; v.pre_din = '0;
    v.an = a; v.sseg = s; v.care = c;
    return v;
  endfunction

  // Starts at the negedge of a frame's first BLANK cycle, ends at the next frame's first cycle.
  task automatic check_frame(input vec_t v, input string tag);
    int d, pos;
    logic [3:0] ea;
    logic [7:0] es;
    logic       sc;
    for (int c = 0; c < FRAME; c++) begin
      d = c / SLOT;
      pos = c % SLOT;
      if (pos < BLANK) begin
        ea = 4'hF; es = 8'hFF; sc = 1'b1;
      end else begin
        ea = v.an[d]; es = v.sseg[d]; sc = v.care[d];
      end
      check($sformatf("%s_an_c%0d", tag, c), 32'(an), 32'(ea));
      if (sc) check($sformatf("%s_sseg_c%0d", tag, c), 32'(sseg), 32'(es));
      if (c > 0) check($sformatf("%s_pulses_c%0d", tag, c), 32'({frame_tick, load_ack}), 32'h0);
      @(negedge clk);
    end
    check({tag, "_end_tick"}, 32'(frame_tick), 32'h1);
    check({tag, "_end_noack"}, 32'(load_ack), 32'h0);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] m);
    load = 1'b1; din = d; dp = p; mask = m;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_ack(input string tag);
    int n = 0;
    while (load_ack !== 1'b1 && n < 3 * FRAME) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ack_seen"}, 32'(load_ack), 32'h1);
    check({tag, "_ack_tick"}, 32'(frame_tick), 32'h1);
  endtask

  vec_t vecs[6];
  vec_t rst_vec;

  initial begin
`ifdef LEADING_ZERO_BLANK_EN
    rst_vec = mk(16'h0000, 4'h0, 4'hF, {4'hF, 4'hF, 4'hF, 4'hE},
                 {8'hFF, 8'hFF, 8'hFF, 8'hC0}, 4'hF);
    vecs[3] = mk(16'h0012, 4'h0, 4'hF, {4'hF, 4'hF, 4'hD, 4'hE},
                 {8'hFF, 8'hFF, 8'hF9, 8'hA4}, 4'hF);
`else
    rst_vec = mk(16'h0000, 4'h0, 4'hF, {4'h7, 4'hB, 4'hD, 4'hE},
                 {8'hC0, 8'hC0, 8'hC0, 8'hC0}, 4'hF);
    vecs[3] = mk(16'h0012, 4'h0, 4'hF, {4'h7, 4'hB, 4'hD, 4'hE},
                 {8'hC0, 8'hC0, 8'hF9, 8'hA4}, 4'hF);
`endif
    vecs[0] = mk(16'h1234, 4'h0, 4'hF, {4'h7, 4'hB, 4'hD, 4'hE},
                 {8'hF9, 8'hA4, 8'hB0, 8'h99}, 4'hF);
    vecs[1] = mk(16'hABCD, 4'h0, 4'hF, {4'h7, 4'hB, 4'hD, 4'hE},
                 {8'h88, 8'h83, 8'hC6, 8'hA1}, 4'hF);
    vecs[1].pre = 1'b1;
    vecs[1].pre_din = 16'h1111;
    vecs[2] = mk(16'h8888, 4'b0010, 4'b0101, {4'hF, 4'hB, 4'hF, 4'hE},
                 {8'h00, 8'h80, 8'h00, 8'h80}, 4'b0101);
    vecs[4] = mk(16'hF0E9, 4'h0, 4'hF, {4'h7, 4'hB, 4'hD, 4'hE},
                 {8'h8E, 8'hC0, 8'h86, 8'h90}, 4'hF);
    vecs[5] = mk(16'h0000, 4'hF, 4'hF, {4'h7, 4'hB, 4'hD, 4'hE},
                 {8'h40, 8'h40, 8'h40, 8'h40}, 4'hF);

    // Reset state, then the first frame from the reset shadow.
    repeat (3) @(negedge clk);
    check("rst_an", 32'(an), 32'hF);
    check("rst_sseg", 32'(sseg), 32'hFF);
    check("rst_pulses", 32'({frame_tick, load_ack}), 32'h0);
    reset_n = 1'b1;
    check_frame(rst_vec, "rst_frame");

    // Table of loads, each verified over the whole following frame.
    foreach (vecs[i]) begin
      if (vecs[i].pre) do_load(vecs[i].pre_din, vecs[i].dp, vecs[i].mask);
      do_load(vecs[i].din, vecs[i].dp, vecs[i].mask);
      wait_ack($sformatf("v%0d", i));
      check_frame(vecs[i], $sformatf("v%0d", i));
    end

    // Load exactly on the commit edge: old data acks now, new data acks one frame later.
    do_load(16'h5555, 4'h0, 4'hF);
    repeat (FRAME - 2) @(negedge clk);
    load = 1'b1; din = 16'h6666; dp = 4'h0; mask = 4'hF;
    @(negedge clk);
    load = 1'b0;
    check("edge_ack_old", 32'(load_ack), 32'h1);
    check("edge_tick_old", 32'(frame_tick), 32'h1);
    repeat (BLANK + 1) @(negedge clk);
    check("edge_old_an", 32'(an), 32'hE);
    check("edge_old_sseg", 32'(sseg), 32'h92);
    repeat (FRAME - BLANK - 1) @(negedge clk);
    check("edge_ack_new", 32'(load_ack), 32'h1);
    repeat (BLANK + 1) @(negedge clk);
    check("edge_new_sseg", 32'(sseg), 32'h82);

    // Reset mid-ON with data still pending: blank before the next edge, shadow cleared.
    do_load(16'h7777, 4'h0, 4'hF);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_an", 32'(an), 32'hF);
    check("midrst_sseg", 32'(sseg), 32'hFF);
    check("midrst_ack", 32'(load_ack), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    check_frame(rst_vec, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
